// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_addsub_if
//  Purpose  : Operand/result bundle for pipelined_addsub. Carries the
//             valid/ready operand beat (a, b, cin, sub) and the valid/ready
//             result beat (sum, cout, ovf).
//  Modports : slave  - the adder's view (consumes operands, produces results)
//             master - the surrounding logic's view (the opposite directions)
//  Revision : 1.0  initial release
// ============================================================================
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_addsub
//  Purpose  : Pipelined carry-propagate adder/subtractor. The WIDTH-bit
//             operands are split into STAGES chunks of CHUNK bits; stage k
//             resolves chunk k and registers its carry for stage k+1.
//             One beat per cycle with valid/ready flow control and
//             backpressure; a full pipe accepts and emits on the same edge.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             bus.slave  in_valid/in_ready/a/b/cin/sub  operand beat
//                        out_valid/out_ready/sum/cout/ovf result beat
//  Function : sub=0 -> sum = a + b + cin ; sub=1 -> sum = a + ~b + 1 (cin
//             ignored). cout is the carry out of the MSB (1 = no borrow when
//             subtracting), ovf is signed two's-complement overflow.
//  Options  : PIPELINED_ADDSUB_SAT_EN - when defined, an overflowing result
//             is replaced by the signed saturation value in the final stage.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipelined_addsub_if.slave bus
);

    localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : 1;
    localparam int LAST  = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be >= 1 and divisible by STAGES >= 1");
    end

    // ------------------------------------------------------------------
    // Flow control. A stage advances when it holds a beat and the stage
    // ahead either is empty or is itself advancing; the chain runs from
    // out_ready back to in_ready combinationally so a full pipe still
    // streams at one beat per cycle.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    always_comb begin
        w_adv       = '0;
        w_adv[LAST] = w_valid[LAST] && bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_adv[k] = w_valid[k] && (!w_valid[k+1] || w_adv[k+1]);
        end
        w_load = ~w_valid | w_adv;
    end

    // in_ready is forced low while reset is asserted, not only after it.
    assign bus.in_ready = !rst && w_load[0];

    // Operand conditioning: subtraction is a + ~b + 1.
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;

    assign w_beff = bus.sub ? ~bus.b : bus.b;
    assign w_c0   = bus.sub | bus.cin;

    // ------------------------------------------------------------------
    // Stages. Stage k sees the operand bits not yet consumed (IW bits,
    // chunk k in the low CHUNK bits) and the partial sum of the lower
    // chunks; it stores PW bits of partial sum and the upper operand bits
    // still to be consumed further up the pipe.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - CHUNK * k;
        localparam int PW = CHUNK * (k + 1);

        logic [IW-1:0]    w_a_in;
        logic [IW-1:0]    w_b_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [CHUNK:0]   w_chunk;
        logic [PW-1:0]    w_psum_new;
        logic [PW-1:0]    w_psum_ld;

        logic             valid_q, valid_d;
        logic             carry_q, carry_d;
        logic [PW-1:0]    psum_q,  psum_d;

        if (k == 0) begin : g_first
            assign w_a_in     = bus.a;
            assign w_b_in     = w_beff;
            assign w_c_in     = w_c0;
            assign w_v_in     = bus.in_valid;
            assign w_psum_new = w_chunk[CHUNK-1:0];
        end else begin : g_next
            assign w_a_in     = g_stage[k-1].g_fwd.a_q;
            assign w_b_in     = g_stage[k-1].g_fwd.b_q;
            assign w_c_in     = g_stage[k-1].carry_q;
            assign w_v_in     = g_stage[k-1].valid_q;
            assign w_psum_new = {w_chunk[CHUNK-1:0], g_stage[k-1].psum_q};
        end

        assign w_chunk    = {1'b0, w_a_in[CHUNK-1:0]}
                          + {1'b0, w_b_in[CHUNK-1:0]}
                          + {{CHUNK{1'b0}}, w_c_in};
        assign w_valid[k] = valid_q;

        // Data registers only move when a real beat enters; otherwise they
        // hold, which keeps the final outputs stable while out_valid is low.
        always_comb begin
            valid_d = w_load[k] ? w_v_in : valid_q;
            carry_d = carry_q;
            psum_d  = psum_q;
            if (w_load[k] && w_v_in) begin
                carry_d = w_chunk[CHUNK];
                psum_d  = w_psum_ld;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                psum_q  <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                psum_q  <= psum_d;
            end
        end

        // Upper operand chunks travel unmodified to the stage that uses them.
        if (k < LAST) begin : g_fwd
            logic [IW-CHUNK-1:0] a_q, a_d;
            logic [IW-CHUNK-1:0] b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (w_load[k] && w_v_in) begin
                    a_d = w_a_in[IW-1:CHUNK];
                    b_d = w_b_in[IW-1:CHUNK];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == LAST) begin : g_final
            logic ovf_q, ovf_d;
            logic w_ovf;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit,
            // so overflow = carry_in(MSB) ^ carry_out(MSB).
            assign w_ovf = w_a_in[CHUNK-1] ^ w_b_in[CHUNK-1]
                         ^ w_chunk[CHUNK-1] ^ w_chunk[CHUNK];

`ifdef PIPELINED_ADDSUB_SAT_EN
            // Overflow only happens when both operands share a sign, so the
            // sign of a gives the direction of the true result.
            logic [WIDTH-1:0] w_sat;

            always_comb begin
                w_sat            = {WIDTH{~w_a_in[CHUNK-1]}};
                w_sat[WIDTH-1]   = w_a_in[CHUNK-1];
            end

            assign w_psum_ld = w_ovf ? w_sat : w_psum_new;
`else
            assign w_psum_ld = w_psum_new;
`endif

            always_comb begin
                ovf_d = ovf_q;
                if (w_load[k] && w_v_in) begin
                    ovf_d = w_ovf;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.out_valid = valid_q;
            assign bus.sum       = psum_q;
            assign bus.cout      = carry_q;
            assign bus.ovf       = ovf_q;
        end else begin : g_mid
            assign w_psum_ld = w_psum_new;
        end
    end

endmodule
`default_nettype wire
